divider_seq: RTL and testbench

Multi-cycle unsigned divider sequencer for the 8085 core's arithmetic section. It owns one `subtractor` instance (chained borrow, `USE_EXTB=0`) and reuses it once per cycle to run a restoring shift-subtract division. Start/busy/done handshake toward the execute unit. Quotient and remainder are held in registers until the next operation completes.

---
 rtl/divider_seq.sv | 166 ++++++++++++++++
 tb/tb_divider_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/divider_seq.sv
// Multi-cycle restoring shift-subtract divider for the 8085 arithmetic section.
// One ripple-borrow subtractor is reused once per cycle; results are held until the next completion.

module subtractor #(
    parameter int DATASIZE = 8,
    parameter int USE_EXTB = 0
) (
    input  logic [DATASIZE-1:0] iJ,
    input  logic [DATASIZE-1:0] iK,
    input  logic                iB,
    output logic [DATASIZE-1:0] oD,
    output logic [DATASIZE-1:0] oB
);

    logic [DATASIZE:0] borrow_chain;

    // With USE_EXTB=0 the chain starts from a zero borrow regardless of iB.
    assign borrow_chain[0] = (USE_EXTB != 0) ? iB : 1'b0;

    generate
        for (genvar gi = 0; gi < DATASIZE; gi++) begin : g_bit
            assign oD[gi]             = iJ[gi] ^ iK[gi] ^ borrow_chain[gi];
            assign borrow_chain[gi+1] = (~iJ[gi] & iK[gi])
                                      | (~(iJ[gi] ^ iK[gi]) & borrow_chain[gi]);
        end
    endgenerate

    assign oB = borrow_chain[DATASIZE:1];

endmodule

module divider_seq #(
    parameter int DATASIZE = 8
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iStart,
    input  logic [DATASIZE-1:0] iDvd,
    input  logic [DATASIZE-1:0] iDvs,
    output logic                oBusy,
    output logic                oDone,
    output logic [DATASIZE-1:0] oQuo,
    output logic [DATASIZE-1:0] oRem,
    output logic                oDZ
);

    localparam int CNT_W = $clog2(DATASIZE + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]          state_reg,  state_next;
    logic [DATASIZE-1:0] part_reg,   part_next;
    logic [DATASIZE-1:0] shq_reg,    shq_next;
    logic [DATASIZE-1:0] dvs_reg,    dvs_next;
    logic [CNT_W-1:0]    cnt_reg,    cnt_next;
    logic [DATASIZE-1:0] quo_reg,    quo_next;
    logic [DATASIZE-1:0] rem_reg,    rem_next;
    logic                dz_reg,     dz_next;

    logic [DATASIZE-1:0] shifted;
    logic                overflow;
    logic [DATASIZE-1:0] sub_diff;
    logic [DATASIZE-1:0] sub_borrow;
    logic [DATASIZE-2:0] borrow_low_unused;
    logic                accept;
    logic [DATASIZE-1:0] iter_part;
    logic [DATASIZE-1:0] iter_shq;

    // The bit shifted out of the partial remainder means S >= 2^DATASIZE > divisor.
    assign shifted  = {part_reg[DATASIZE-2:0], shq_reg[DATASIZE-1]};
    assign overflow = part_reg[DATASIZE-1];

    subtractor #(
        .DATASIZE (DATASIZE),
        .USE_EXTB (0)
    ) u_sub (
        .iJ (shifted),
        .iK (dvs_reg),
        .iB (1'b0),
        .oD (sub_diff),
        .oB (sub_borrow)
    );

    assign borrow_low_unused = sub_borrow[DATASIZE-2:0];

    assign accept    = overflow | ~sub_borrow[DATASIZE-1];
    assign iter_part = accept ? sub_diff : shifted;
    assign iter_shq  = {shq_reg[DATASIZE-2:0], accept};

    always_comb begin
        state_next = state_reg;
        part_next  = part_reg;
        shq_next   = shq_reg;
        dvs_next   = dvs_reg;
        cnt_next   = cnt_reg;
        quo_next   = quo_reg;
        rem_next   = rem_reg;
        dz_next    = dz_reg;
        case (state_reg)
            ST_IDLE: begin
                if (iStart) begin
                    if (iDvs != '0) begin
                        part_next  = '0;
                        shq_next   = iDvd;
                        dvs_next   = iDvs;
                        cnt_next   = CNT_W'(DATASIZE);
                        state_next = ST_RUN;
                    end else begin
                        quo_next   = '1;
                        rem_next   = iDvd;
                        dz_next    = 1'b1;
                        state_next = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                part_next = iter_part;
                shq_next  = iter_shq;
                cnt_next  = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    quo_next   = iter_shq;
                    rem_next   = iter_part;
                    dz_next    = 1'b0;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_reg <= ST_IDLE;
            part_reg  <= '0;
            shq_reg   <= '0;
            dvs_reg   <= '0;
            cnt_reg   <= '0;
            quo_reg   <= '0;
            rem_reg   <= '0;
            dz_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            part_reg  <= part_next;
            shq_reg   <= shq_next;
            dvs_reg   <= dvs_next;
            cnt_reg   <= cnt_next;
            quo_reg   <= quo_next;
            rem_reg   <= rem_next;
            dz_reg    <= dz_next;
        end
    end

    assign oBusy = (state_reg == ST_RUN);
    assign oDone = (state_reg == ST_DONE);
    assign oQuo  = quo_reg;
    assign oRem  = rem_reg;
    assign oDZ   = dz_reg;

endmodule

// File: tb/tb_divider_seq.sv
// Scoreboard bench for divider_seq: stimulus pushes expected results and completion cycles,
// a monitor checks busy/done/results every cycle against them.

module tb_divider_seq;

    localparam int DS = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DS-1:0] dvd = '0;
    logic [DS-1:0] dvs = '0;
    logic          busy;
    logic          done;
    logic [DS-1:0] quo;
    logic [DS-1:0] rem;
    logic          dz;

    divider_seq #(.DATASIZE(DS)) dut (
        .iClk   (clk),
        .iRst   (rst_n),
        .iStart (start),
        .iDvd   (dvd),
        .iDvs   (dvs),
        .oBusy  (busy),
        .oDone  (done),
        .oQuo   (quo),
        .oRem   (rem),
        .oDZ    (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned quo;
        int unsigned rem;
        bit          dz;
        int          done_cyc;
        int unsigned a;
        int unsigned b;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned last_quo = 0;
    int unsigned last_rem = 0;
    bit          last_dz = 1'b0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, req);
        end
    endtask

    // Monitor: sampled 1 time unit after each rising edge.
    initial begin
        bit   exp_done;
        bit   exp_busy;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                exp_done = (sb.size() > 0) && (cyc == sb[0].done_cyc);
                exp_busy = (sb.size() > 0) && !sb[0].dz
                           && (cyc >= sb[0].done_cyc - DS) && (cyc < sb[0].done_cyc);
                chk("done", done, exp_done);
                chk("busy", busy, exp_busy);
                if (exp_done) begin
                    e = sb.pop_front();
                    last_quo = e.quo;
                    last_rem = e.rem;
                    last_dz  = e.dz;
                    $display("op %0d/%0d -> q=%0d r=%0d dz=%0b (cyc %0d)",
                             e.a, e.b, quo, rem, dz, cyc);
                end
                chk("quo", quo, last_quo);
                chk("rem", rem, last_rem);
                chk("dz", dz, last_dz);
            end
        end
    end

    // Drive one operation at a falling edge; returns at the falling edge of the next legal start slot.
    task automatic run_op(input int unsigned a, input int unsigned b, input bit keep_start);
        exp_t e;
        e.a  = a;
        e.b  = b;
        e.dz = (b == 0);
        e.quo = e.dz ? (2**DS - 1) : a / b;
        e.rem = e.dz ? a : a % b;
        e.done_cyc = cyc + 1 + (e.dz ? 0 : DS);
        sb.push_back(e);
        dvd   = DS'(a);
        dvs   = DS'(b);
        start = 1'b1;
        @(negedge clk);
        if (!keep_start) start = 1'b0;
        dvd = DS'($urandom_range(0, 255));
        dvs = DS'($urandom_range(0, 255));
        repeat (e.dz ? 1 : DS + 1) @(negedge clk);
    endtask

    initial begin
        int unsigned dir_a[9] = '{200, 255, 255, 5, 0, 254, 77, 10, 100};
        int unsigned dir_b[9] = '{7, 1, 255, 9, 13, 128, 0, 3, 10};
        int          waited;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_quo", quo, 0);
        chk("reset_rem", rem, 0);
        chk("reset_dz", dz, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Abort 200/7 mid-run, then 9/3 right after reset release.
        run_op(9, 3, 0);
        begin
            exp_t e;
            e.a = 200; e.b = 7; e.dz = 0; e.quo = 28; e.rem = 4;
            e.done_cyc = cyc + 1 + DS;
            sb.push_back(e);
        end
        dvd = 8'd200; dvs = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        last_quo = 0; last_rem = 0; last_dz = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_quo", quo, 0);
        chk("abort_rem", rem, 0);
        chk("abort_dz", dz, 0);
        repeat (DS + 3) @(negedge clk);
        rst_n = 1'b1;
        run_op(9, 3, 0);

        for (int i = 0; i < 9; i++) run_op(dir_a[i], dir_b[i], 0);

        // Start pulses during RUN and DONE of 100/10 must be ignored.
        begin
            exp_t e;
            e.a = 100; e.b = 10; e.dz = 0; e.quo = 10; e.rem = 0;
            e.done_cyc = cyc + 1 + DS;
            sb.push_back(e);
        end
        dvd = 8'd100; dvs = 8'd10; start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < DS + 1; i++) begin
            start = (i % 3 != 1);
            dvd   = DS'($urandom_range(0, 255));
            dvs   = DS'($urandom_range(0, 255));
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);

        // Random back-to-back sweep with start held high.
        for (int i = 0; i < 2500; i++) begin
            int unsigned a;
            int unsigned b;
            a = $urandom_range(0, 255);
            b = (i % 97 == 5) ? 0 : $urandom_range(0, 255);
            run_op(a, b, 1);
        end
        start = 1'b0;

        waited = 0;
        while (sb.size() > 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
